// File: rtl/mic_sample_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : mic_sample_scheduler_if
//  Description : Bundle of all non-clock signals of mic_sample_scheduler.
//                Suffixes are from the scheduler's point of view.
//                  en_i/period_i       : sampling enable and period in cycles
//                  start_o/done_i      : handshake with the SPI receiver
//                  data_i              : receiver word (low 12 bits used)
//                  sample_o/_valid_o   : FIFO head towards the DSP consumer
//                  sample_ready_i      : consumer accept
//                  level_o             : FIFO occupancy
//                  overrun_o/missed_o/timeout_o : sticky error flags
//                  clr_err_i           : clears the sticky flags
//                master = scheduler side, slave = environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mic_sample_scheduler_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          en_i;
    logic [15:0]   period_i;
    logic          start_o;
    logic          done_i;
    logic [15:0]   data_i;
    logic [11:0]   sample_o;
    logic          sample_valid_o;
    logic          sample_ready_i;
    logic [LW-1:0] level_o;
    logic          overrun_o;
    logic          missed_o;
    logic          timeout_o;
    logic          clr_err_i;

    modport master (
        input  en_i, period_i, done_i, data_i, sample_ready_i, clr_err_i,
        output start_o, sample_o, sample_valid_o, level_o,
               overrun_o, missed_o, timeout_o
    );

    modport slave (
        output en_i, period_i, done_i, data_i, sample_ready_i, clr_err_i,
        input  start_o, sample_o, sample_valid_o, level_o,
               overrun_o, missed_o, timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/mic_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mic_sample_scheduler
//  Description : Periodically starts conversions on an SPI microphone
//                receiver via a START/DONE handshake, extracts the 12-bit
//                sample and buffers it in a first-word-fall-through FIFO
//                drained by a valid/ready consumer. Reports sticky overrun,
//                missed-tick and handshake-timeout errors.
//  Ports       : clk_i   - system clock (receiver domain)
//                rst_ni  - synchronous active-low reset
//                bus     - mic_sample_scheduler_if.master (all other signals)
//  Option      : MIC_AVG4_EN - when defined, four consecutive captures are
//                averaged and only the average is pushed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mic_sample_scheduler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    mic_sample_scheduler_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    // ---------------- DONE synchronizer (idle level is 1) ------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   w_ds;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) sync_q <= '1;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.done_i};
    end
    assign w_ds = sync_q[SYNC_STAGES-1];

    // ---------------- Period counter ---------------------------------------
    // per_q holds the period in use; it is reloaded only at a wrap (or while
    // disabled) so a PERIOD change never truncates a running interval.
    logic [15:0] cnt_q, cnt_d, per_q, per_d, w_lim;
    logic        w_tick;

    assign w_lim  = (per_q == 16'd0) ? 16'd0 : per_q - 16'd1;
    assign w_tick = bus.en_i && (cnt_q == w_lim);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        per_d = per_q;
        if (!bus.en_i || w_tick) begin
            cnt_d = 16'd0;
            per_d = bus.period_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 16'd0;
            per_q <= bus.period_i;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

    // ---------------- Handshake FSM ----------------------------------------
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          w_tmo_hit, w_start, w_capture, w_timeout_set, w_missed_set;

    assign w_tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // A real handshake progress wins over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (w_tick && w_ds) state_d = S_REQ;
            S_REQ:     if (!w_ds)          state_d = S_BUSY;
                       else if (w_tmo_hit) state_d = S_IDLE;
            S_BUSY:    if (w_ds)           state_d = S_CAPTURE;
                       else if (w_tmo_hit) state_d = S_IDLE;
            S_CAPTURE:                     state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
        // Counter restarts on every state entry.
        tmo_d = (state_d != state_q) ? '0 : tmo_q + TW'(1);
    end

    always_comb begin
        w_start       = 1'b0;
        w_capture     = 1'b0;
        w_timeout_set = 1'b0;
        case (state_q)
            S_REQ: begin
                w_start       = 1'b1;
                w_timeout_set = w_ds && w_tmo_hit;
            end
            S_BUSY:    w_timeout_set = !w_ds && w_tmo_hit;
            S_CAPTURE: w_capture     = 1'b1;
            default:   ;
        endcase
    end

    // Ticks are never queued: any tick that cannot start a request is lost.
    assign w_missed_set = w_tick && ((state_q != S_IDLE) || !w_ds);

    // ---------------- Push source ------------------------------------------
    logic        w_push;
    logic [11:0] w_push_data;

`ifdef MIC_AVG4_EN
    logic [13:0] acc_q, acc_d, w_sum;
    logic [1:0]  ph_q, ph_d;

    assign w_sum = acc_q + {2'b00, bus.data_i[11:0]};

    always_comb begin
        acc_d       = acc_q;
        ph_d        = ph_q;
        w_push      = 1'b0;
        w_push_data = w_sum[13:2];
        if (!bus.en_i) begin
            acc_d = '0;
            ph_d  = '0;
        end else if (w_capture) begin
            if (ph_q == 2'd3) begin
                w_push = 1'b1;
                acc_d  = '0;
                ph_d   = '0;
            end else begin
                acc_d = w_sum;
                ph_d  = ph_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
            ph_q  <= '0;
        end else begin
            acc_q <= acc_d;
            ph_q  <= ph_d;
        end
    end

    wire w_unused = &{1'b0, bus.data_i[15:12], w_sum[1:0]};
`else
    assign w_push      = w_capture;
    assign w_push_data = bus.data_i[11:0];

    wire w_unused = &{1'b0, bus.data_i[15:12]};
`endif

    // ---------------- Sample FIFO (FWFT, registered head) ------------------
    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic [11:0]   smp_q, smp_d;
    logic          vld_q, vld_d;
    logic          w_full, w_pop, w_wr, w_ovr_set;

    assign w_full    = (lvl_q == LW'(FIFO_DEPTH));
    assign w_pop     = vld_q && bus.sample_ready_i;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    always_comb begin
        wr_d  = w_wr  ? wr_q + AW'(1) : wr_q;
        rd_d  = w_pop ? rd_q + AW'(1) : rd_q;
        lvl_d = lvl_q + {{(LW-1){1'b0}}, w_wr} - {{(LW-1){1'b0}}, w_pop};
        vld_d = (lvl_d != '0);
        smp_d = smp_q;
        // The new head is either an already-stored entry or, when the FIFO
        // would otherwise be empty, the word being written this cycle.
        if (vld_d)
            smp_d = (w_wr && (rd_d == wr_q)) ? w_push_data : mem_q[rd_d];
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) mem_q[wr_q] <= w_push_data;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            smp_q <= '0;
            vld_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
            smp_q <= smp_d;
            vld_q <= vld_d;
        end
    end

    // ---------------- Sticky error flags (set beats clear) -----------------
    logic ovr_q, mis_q, tmo_flag_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovr_q      <= 1'b0;
            mis_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            ovr_q      <= w_ovr_set     | (ovr_q      & ~bus.clr_err_i);
            mis_q      <= w_missed_set  | (mis_q      & ~bus.clr_err_i);
            tmo_flag_q <= w_timeout_set | (tmo_flag_q & ~bus.clr_err_i);
        end
    end

    // ---------------- Outputs ----------------------------------------------
    assign bus.start_o        = w_start;
    assign bus.sample_o       = smp_q;
    assign bus.sample_valid_o = vld_q;
    assign bus.level_o        = lvl_q;
    assign bus.overrun_o      = ovr_q;
    assign bus.missed_o       = mis_q;
    assign bus.timeout_o      = tmo_flag_q;

endmodule
`default_nettype wire

// File: doc/mic_sample_scheduler.md
Name: mic_sample_scheduler

Overview:
Sequences the 16-bit SPI microphone receiver at a programmable sample rate. Each conversion is started with a START/DONE handshake. The 12-bit sample is extracted from the received word and buffered in a small FIFO, which a downstream DSP consumer drains through a valid/ready interface. Sits between the SPI receiver and the audio processing path. Also reports overrun, missed-tick and timeout errors.

Parameters:
FIFO_DEPTH, 8, sample FIFO entries; power of two, minimum 2.
SYNC_STAGES, 2, flops in the DONE synchronizer; minimum 2.
TIMEOUT_CYC, 1024, CLK cycles allowed per handshake phase before TIMEOUT is raised.

Ports:
CLK  in  1  system clock; the receiver's clock domain.
RST_N  in  1  reset; synchronous, active-low.
EN  in  1  enable periodic sampling.
PERIOD  in  16  sample period in CLK cycles; 0 and 1 both mean a tick every cycle.
START  out  1  conversion request to the SPI receiver.
DONE  in  1  receiver idle/done flag; asynchronous, low while busy.
DATA  in  16  receiver output word; stable while DONE is high.
SAMPLE  out  12  FIFO head sample.
SAMPLE_VALID  out  1  FIFO not empty.
SAMPLE_READY  in  1  consumer accepts SAMPLE.
LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
OVERRUN  out  1  sticky: a sample was dropped because the FIFO was full.
MISSED  out  1  sticky: a tick arrived while a conversion was in progress.
TIMEOUT  out  1  sticky: a handshake phase exceeded TIMEOUT_CYC.
CLR_ERR  in  1  clears all three sticky flags.

Behaviour:
- Reset values: START=0, SAMPLE=0, SAMPLE_VALID=0, LEVEL=0, OVERRUN=0, MISSED=0, TIMEOUT=0. Reset also empties the FIFO, clears the period counter and timeout counter, puts the FSM in IDLE and loads the synchronizer with 1.
- Reset mid-conversion: START drops the next cycle. The receiver is left to finish on its own.
- DONE handling: passes through SYNC_STAGES flops; the synchronized value is called ds. All decisions use ds.
- Period counter:
  - Runs only while EN=1; held at 0 while EN=0.
  - Produces a 1-cycle tick when the count reaches max(PERIOD,1)-1, then wraps to 0.
  - A PERIOD change takes effect at the next wrap.
- FSM states:
  - IDLE: START=0. On a tick with ds=1, go to REQ. On a tick with ds=0, set MISSED and stay in IDLE.
  - REQ: START=1. When ds=0, go to BUSY.
  - BUSY: START=0. When ds=1, go to CAPTURE.
  - CAPTURE: 1 cycle. Register DATA[11:0], push it into the FIFO (or the averager), return to IDLE.
- Timeout:
  - The timeout counter resets on every state entry.
  - If REQ or BUSY lasts TIMEOUT_CYC cycles: set TIMEOUT, drive START=0, return to IDLE, push nothing.
- Tick collisions: a tick while in REQ, BUSY or CAPTURE sets MISSED and is dropped. Ticks are never queued.
- EN deasserted mid-conversion: the current handshake completes and its sample is captured. No new REQ is entered.
- FIFO:
  - First-word-fall-through. SAMPLE and SAMPLE_VALID are registered.
  - A push becomes visible on SAMPLE_VALID the cycle after CAPTURE.
  - Pop happens when SAMPLE_VALID & SAMPLE_READY.
  - A push when full is dropped and sets OVERRUN, unless a pop occurs in the same cycle; then both happen and LEVEL is unchanged.
  - A pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: CLR_ERR clears them. If CLR_ERR and a new set event occur in the same cycle, set wins.

Optional Feature:
Macro: MIC_AVG4_EN.
- Defined:
  - Captured samples accumulate in a 14-bit register.
  - Every 4th capture pushes sum[13:2] and clears the accumulator.
  - The accumulator and the phase counter clear on EN=0 and on reset.
  - OVERRUN applies only to the averaged push.
- Not defined: every capture pushes DATA[11:0] directly; no accumulator logic is present.

Test Plan:
- PERIOD=200, EN=1; receiver model returns 0x0ABC (DONE low for 40 cycles) -> one START per 200 cycles; SAMPLE=0xABC with SAMPLE_VALID high; LEVEL=1; no error flags.
- READY=0, 9 conversions with FIFO_DEPTH=8 -> LEVEL=8; OVERRUN=1; the first 8 samples are popped in order once READY=1.
- PERIOD=10, conversion lasting 60 cycles -> MISSED=1; every START is separated by a full handshake; CLR_ERR=1 clears MISSED to 0.
- DONE stuck high after START -> TIMEOUT=1 at REQ entry+1024 cycles; START=0; LEVEL unchanged.
- FIFO full with push and pop in the same cycle -> LEVEL stays 8; OVERRUN stays 0; head advances.
- MIC_AVG4_EN defined, inputs 0x100, 0x200, 0x300, 0x400 -> single push of 0x280 after the 4th capture.
